// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Purpose  : Data-memory bridge between a CPU load/store port and a
//            word-organised RAM plus a small MMIO window (LEDs, switches,
//            free-running cycle counter). Each access takes a fixed
//            IDLE -> BUSY -> RESP walk and completes with a one-cycle
//            MIO_ready pulse.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            mem_w, mem_r    - store / load request (both high = store)
//            Addr_in         - byte address
//            Data_in         - store data
//            dm_ctrl         - 000 word, 001 half s, 010 half u,
//                              011 byte s, 100 byte u (others = word)
//            Data_out        - extended load data, held outside RESP
//            MIO_ready       - completion pulse
//            misalign        - misaligned-access flag (RESP only)
//            sw_in, led_out  - switch inputs, LED register low half
// Options  : DMEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//            accesses raise misalign, drop the store and return 0.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic        misalign,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  ctrl_q;
  logic        store_q;
  logic [31:0] led_reg;
  logic [31:0] cycle_cnt;

  logic [31:0] ram [DEPTH];

  // Decode of the captured request, only consumed while in BUSY.
  logic          is_half;
  logic          is_byte;
  logic          is_mmio;
  logic [31:0]   mmio_off;
  logic [AW-1:0] ram_idx;
  logic          misaligned;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic [31:0]   ram_word;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   ram_load;
  logic [31:0]   mmio_load;
  logic [31:0]   load_data;

  always_comb begin
    is_half     = (ctrl_q == 3'b001) || (ctrl_q == 3'b010);
    is_byte     = (ctrl_q == 3'b011) || (ctrl_q == 3'b100);
    is_mmio     = (addr_q >= MMIO_BASE);
    mmio_off    = addr_q - MMIO_BASE;
    ram_idx     = addr_q[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    // MMIO is always a full-word access, so it shares the word rule.
    if (is_mmio)      misaligned = (addr_q[1:0] != 2'b00);
    else if (is_half) misaligned = addr_q[0];
    else if (is_byte) misaligned = 1'b0;
    else              misaligned = (addr_q[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif

    // Store lanes: replicate the narrow datum across the word and let the
    // byte enables pick the lanes that actually get written.
    if (is_half) begin
      byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_lanes = {2{wdata_q[15:0]}};
    end else if (is_byte) begin
      byte_en     = 4'b0001 << addr_q[1:0];
      wdata_lanes = {4{wdata_q[7:0]}};
    end else begin
      byte_en     = 4'b1111;
      wdata_lanes = wdata_q;
    end

    ram_word  = ram[ram_idx];
    lane_byte = 8'(ram_word >> {addr_q[1:0], 3'b000});
    lane_half = addr_q[1] ? ram_word[31:16] : ram_word[15:0];

    case (ctrl_q)
      3'b001:  ram_load = {{16{lane_half[15]}}, lane_half};
      3'b010:  ram_load = {16'h0000, lane_half};
      3'b011:  ram_load = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  ram_load = {24'h000000, lane_byte};
      default: ram_load = ram_word;
    endcase

    case (mmio_off)
      32'd0:   mmio_load = led_reg;
      32'd4:   mmio_load = {16'h0000, sw_in};
      32'd8:   mmio_load = cycle_cnt;
      default: mmio_load = 32'h0000_0000;
    endcase

    if (misaligned)   load_data = 32'h0000_0000;
    else if (is_mmio) load_data = mmio_load;
    else              load_data = ram_load;
  end

  // Control path and MMIO registers. Reset in BUSY simply lands here in
  // IDLE, so the pending access never commits and never responds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      MIO_ready <= 1'b0;
      misalign  <= 1'b0;
      Data_out  <= 32'h0000_0000;
      led_reg   <= 32'h0000_0000;
      cycle_cnt <= 32'h0000_0000;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      ctrl_q    <= 3'b000;
      store_q   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      MIO_ready <= 1'b0;
      misalign  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_w || mem_r) begin
            addr_q  <= Addr_in;
            wdata_q <= Data_in;
            ctrl_q  <= dm_ctrl;
            store_q <= mem_w;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (store_q && !misaligned && is_mmio && (mmio_off == 32'd0)) begin
            led_reg <= wdata_q;
          end
          // Plain stores leave Data_out alone; a trapped store reports 0.
          if (!store_q || misaligned) begin
            Data_out <= load_data;
          end
          MIO_ready <= 1'b1;
          misalign  <= misaligned;
          state     <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM write port, kept free of reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_BUSY) && store_q && !misaligned && !is_mmio) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          ram[ram_idx][8*k +: 8] <= wdata_lanes[8*k +: 8];
        end
      end
    end
  end

  assign led_out = led_reg[15:0];

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Purpose  : Self-checking bench for dmem_bridge. A transaction-level model
//            (word array, LED register, cycle count) predicts every access;
//            a per-cycle compare process checks MIO_ready, misalign,
//            Data_out and led_out, and literal checks pin key results.
// Options  : DMEM_MISALIGN_TRAP_EN selects the trapping expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

  localparam int          DEPTH     = 1024;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_w = 1'b0;
  logic        mem_r = 1'b0;
  logic [31:0] Addr_in = '0;
  logic [31:0] Data_in = '0;
  logic [2:0]  dm_ctrl = '0;
  logic [31:0] Data_out;
  logic        MIO_ready;
  logic        misalign;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;

  dmem_bridge #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .mem_r(mem_r),
    .Addr_in(Addr_in), .Data_in(Data_in), .dm_ctrl(dm_ctrl),
    .Data_out(Data_out), .MIO_ready(MIO_ready), .misalign(misalign),
    .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int          n = 0;           // rising edges seen
  logic [31:0] cnt_m = '0;      // cycles since reset released
  logic [31:0] mem_m [int];     // RAM words by word index
  logic [31:0] led_m = '0;      // LED register, committed view
  bit          pending = 0;
  int          resp_n = 0;
  bit          pend_load = 0;
  logic [31:0] pend_dout = '0;
  bit          pend_led = 0;
  logic [31:0] pend_led_val = '0;
  bit          pend_mis = 0;
  logic [31:0] exp_dout = '0;
  logic [31:0] exp_led = '0;
  int          last_ready_n = -100;
  bit          chk_en = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) begin
    n <= n + 1;
    if (rst) cnt_m <= '0;
    else     cnt_m <= cnt_m + 32'd1;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (edge %0d)", name, act, exp, n);
    end
  endtask

  // Access class from dm_ctrl: 1 byte, 2 half, 4 word.
  function automatic int size_of(input logic [2:0] c);
    if (c == 3'b001 || c == 3'b010) return 2;
    if (c == 3'b011 || c == 3'b100) return 1;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [31:0] a, input logic [2:0] c);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a >= MMIO_BASE) return (a % 4) != 0;
    if (size_of(c) == 2) return (a % 2) != 0;
    if (size_of(c) == 4) return (a % 4) != 0;
    return 0;
`else
    return 0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    if (a >= MMIO_BASE) begin
      case (a - MMIO_BASE)
        32'd0:   return led_m;
        32'd4:   return {16'h0000, sw_in};
        32'd8:   return cnt_m + 32'd1;   // counter value at the executing edge
        default: return 32'h0;
      endcase
    end
    w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'h0;
    b = w[8*(a%4) +: 8];
    h = w[16*((a/2)%2) +: 16];
    case (c)
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {16'h0, h};
      3'b011:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    logic [31:0] w;
    if (a >= MMIO_BASE) begin
      if (a - MMIO_BASE == 32'd0) begin
        led_m = d; pend_led = 1; pend_led_val = d;
      end
      return;
    end
    w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'h0;
    case (size_of(c))
      1:       w[8*(a%4) +: 8]       = d[7:0];
      2:       w[16*((a/2)%2) +: 16] = d[15:0];
      default: w                     = d;
    endcase
    mem_m[widx(a)] = w;
  endtask

  // Per-cycle comparison of every observable output.
  always @(negedge clk) begin : p_cmp
    bit er;
    bit em;
    if (chk_en) begin
      er = 0;
      em = 0;
      if (pending && n == resp_n) begin
        er = 1;
        em = pend_mis;
        if (pend_load) exp_dout = pend_dout;
        if (pend_led)  exp_led  = pend_led_val;
        pending = 0;
      end
      if (MIO_ready) last_ready_n = n;
      check32("MIO_ready", {31'h0, MIO_ready}, {31'h0, er});
      check32("misalign",  {31'h0, misalign},  {31'h0, em});
      check32("Data_out",  Data_out, exp_dout);
      check32("led_out",   {16'h0, led_out}, {16'h0, exp_led[15:0]});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One complete access; a junk request is held through BUSY/RESP to show
  // it is ignored (it would overwrite the LED register otherwise).
  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] c);
    int m0;
    m0 = n;
    pending = 1; resp_n = n + 2; pend_led = 0; pend_load = 0;
    pend_mis = model_mis(a, c);
    if (pend_mis) begin
      pend_load = 1; pend_dout = 32'h0;
    end else if (w) begin
      model_store(a, d, c);
    end else begin
      pend_load = 1; pend_dout = model_load(a, c);
    end
    mem_w = w; mem_r = r; Addr_in = a; Data_in = d; dm_ctrl = c;
    step();
    mem_w = 1; mem_r = 1; Addr_in = MMIO_BASE; Data_in = 32'hFFFF_FFFF; dm_ctrl = 3'b000;
    step();
    step();
    mem_w = 0; mem_r = 0; Addr_in = '0; Data_in = '0; dm_ctrl = '0;
    check32("latency", last_ready_n - m0, 32'd2);
  endtask

  logic [31:0] c1, c2;

  initial begin
    @(posedge clk);
    #1 chk_en = 1;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    step();

    // Word store / load round trip.
    access(1, 0, 32'h10, 32'hDEADBEEF, 3'b000);
    access(0, 1, 32'h10, 32'h0, 3'b000);
    check32("lw_0x10", Data_out, 32'hDEADBEEF);

    // Byte lane 3 store, then byte and word loads.
    access(1, 0, 32'h13, 32'h0000005A, 3'b100);
    access(0, 1, 32'h12, 32'h0, 3'b011);
    check32("lb_0x12", Data_out, 32'hFFFFFFAD);
    access(0, 1, 32'h11, 32'h0, 3'b100);
    check32("lbu_0x11", Data_out, 32'h000000BE);
    access(0, 1, 32'h10, 32'h0, 3'b000);
    check32("lw_0x10_b", Data_out, 32'h5AADBEEF);

    // Upper half store and both extensions.
    access(1, 0, 32'h22, 32'h00008001, 3'b001);
    access(0, 1, 32'h22, 32'h0, 3'b001);
    check32("lh_0x22", Data_out, 32'hFFFF8001);
    access(0, 1, 32'h22, 32'h0, 3'b010);
    check32("lhu_0x22", Data_out, 32'h00008001);

    // Both request lines high behaves as a store.
    access(1, 1, 32'h30, 32'h13572468, 3'b000);
    access(0, 1, 32'h30, 32'h0, 3'b000);
    check32("lw_0x30", Data_out, 32'h13572468);

    // MMIO: LED write with a byte code, RO write ignored, switch read.
    access(1, 0, MMIO_BASE, 32'h0000ABCD, 3'b011);
    access(1, 0, MMIO_BASE + 32'd4, 32'h0000FFFF, 3'b000);
    check32("led_lit", {16'h0, led_out}, 32'h0000ABCD);
    sw_in = 16'h1234;
    access(0, 1, MMIO_BASE + 32'd4, 32'h0, 3'b100);
    check32("sw_rd", Data_out, 32'h00001234);
    access(0, 1, MMIO_BASE, 32'h0, 3'b000);
    check32("led_rd", Data_out, 32'h0000ABCD);
    access(0, 1, MMIO_BASE + 32'd12, 32'h0, 3'b000);
    check32("unmapped_rd", Data_out, 32'h0);
    access(0, 1, MMIO_BASE + 32'd8, 32'h0, 3'b000);
    c1 = Data_out;
    access(0, 1, MMIO_BASE + 32'd8, 32'h0, 3'b000);
    c2 = Data_out;
    check32("cnt_delta", c2 - c1, 32'd3);

    // Reset during BUSY aborts the store and keeps RAM contents.
    access(1, 0, 32'h40, 32'hCAFEF00D, 3'b000);
    mem_w = 1; Addr_in = 32'h40; Data_in = 32'h12345678; dm_ctrl = 3'b000;
    step();
    mem_w = 0;
    rst = 1;
    led_m = '0; exp_led = '0; exp_dout = '0; pending = 0;
    step();
    rst = 0;
    step();
    step();
    check32("led_after_rst", {16'h0, led_out}, 32'h0);
    access(0, 1, 32'h40, 32'h0, 3'b000);
    check32("lw_0x40_abort", Data_out, 32'hCAFEF00D);

    // Misaligned word store.
    access(1, 0, 32'h41, 32'h11111111, 3'b000);
    access(0, 1, 32'h40, 32'h0, 3'b000);
`ifdef DMEM_MISALIGN_TRAP_EN
    check32("lw_0x40_mis", Data_out, 32'hCAFEF00D);
`else
    check32("lw_0x40_mis", Data_out, 32'h11111111);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
